// File: rtl/cia_eclk_bus_sync.sv
// cia_eclk_bus_sync
// Synchronises CPU peripheral accesses to the 8520 CIAs with the 0.709 MHz
// E clock (6800-style VPA/VMA cycle emulation). It waits for E alignment,
// asserts VMA, opens the CIA select window during E high, and at the end of
// E high issues a transfer strobe, latches read data and acknowledges.
//
// Ports:
//   clk_28    in   28 MHz system clock, all logic on posedge
//   rst_n     in   asynchronous active-low reset
//   clk7_en   in   7 MHz enable, one clk_28 cycle in four
//   eclk      in   one-hot E phase (bit n = E counter value n)
//   req       in   CPU peripheral-access request, held until ack
//   rnw       in   1 = read, 0 = write, sampled when the request is accepted
//   cia_dout  in   read data from CIA
//   vma       out  valid memory address
//   e_lvl     out  registered E level
//   cia_sel   out  CIA chip-select window (E high)
//   cia_we    out  write enable, only meaningful while cia_sel = 1
//   strobe    out  one-clk_28 transfer strobe at end of E high
//   ack       out  one-clk_28 completion pulse to CPU
//   rdat      out  latched read data
//   wait_cnt  out  clk7 periods spent waiting for E alignment (saturating)
module cia_eclk_bus_sync #(
  parameter int unsigned WAIT_W = 8
) (
  input  logic              clk_28,
  input  logic              rst_n,
  input  logic              clk7_en,
  input  logic [9:0]        eclk,
  input  logic              req,
  input  logic              rnw,
  input  logic [7:0]        cia_dout,
  output logic              vma,
  output logic              e_lvl,
  output logic              cia_sel,
  output logic              cia_we,
  output logic              strobe,
  output logic              ack,
  output logic [7:0]        rdat,
  output logic [WAIT_W-1:0] wait_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_VMA,
    S_EHI,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                vma_q, vma_d;
  logic                e_lvl_q, e_lvl_d;
  logic                cia_sel_q, cia_sel_d;
  logic                cia_we_q, cia_we_d;
  logic                strobe_q, strobe_d;
  logic                ack_q, ack_d;
  logic [7:0]          rdat_q, rdat_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                rnw_q, rnw_d;

  always_comb begin
    state_d    = state_q;
    vma_d      = vma_q;
    cia_sel_d  = cia_sel_q;
    cia_we_d   = cia_we_q;
    rdat_d     = rdat_q;
    wait_cnt_d = wait_cnt_q;
    rnw_d      = rnw_q;
    // Pulses self-clear on the very next clk_28, not the next clk7 edge.
    strobe_d   = 1'b0;
    ack_d      = 1'b0;
    // E is high for counter values 6..9; tracked every clk_28 regardless of state.
    e_lvl_d    = |eclk[9:6];

    if (clk7_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            state_d    = S_SYNC;
            rnw_d      = rnw;
            wait_cnt_d = '0;
          end
        end
        S_SYNC: begin
          if (!req) begin
            state_d = S_IDLE;
          end else if (eclk[2]) begin
            state_d = S_VMA;
            vma_d   = 1'b1;
          end else if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        S_VMA: begin
          // req is no longer consulted: once VMA is out the cycle must complete.
          if (eclk[5]) begin
            state_d   = S_EHI;
            cia_sel_d = 1'b1;
            cia_we_d  = ~rnw_q;
          end
        end
        S_EHI: begin
          if (eclk[9]) begin
            state_d   = S_DONE;
            strobe_d  = 1'b1;
            ack_d     = 1'b1;
            vma_d     = 1'b0;
            cia_sel_d = 1'b0;
            cia_we_d  = 1'b0;
            if (rnw_q) rdat_d = cia_dout;
          end
        end
        S_DONE: begin
          // A held request must be released before another access may start.
          if (!req) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      vma_q      <= 1'b0;
      e_lvl_q    <= 1'b0;
      cia_sel_q  <= 1'b0;
      cia_we_q   <= 1'b0;
      strobe_q   <= 1'b0;
      ack_q      <= 1'b0;
      rdat_q     <= '0;
      wait_cnt_q <= '0;
      rnw_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      vma_q      <= vma_d;
      e_lvl_q    <= e_lvl_d;
      cia_sel_q  <= cia_sel_d;
      cia_we_q   <= cia_we_d;
      strobe_q   <= strobe_d;
      ack_q      <= ack_d;
      rdat_q     <= rdat_d;
      wait_cnt_q <= wait_cnt_d;
      rnw_q      <= rnw_d;
    end
  end

  assign vma      = vma_q;
  assign e_lvl    = e_lvl_q;
  assign cia_sel  = cia_sel_q;
  assign cia_we   = cia_we_q;
  assign strobe   = strobe_q;
  assign ack      = ack_q;
  assign rdat     = rdat_q;
  assign wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_cia_eclk_bus_sync.sv
module tb_cia_eclk_bus_sync;

  logic       clk_28 = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk7_en = 1'b1;
  logic [9:0] eclk = 10'd1;
  logic       req = 1'b0;
  logic       rnw = 1'b1;
  logic [7:0] cia_dout = 8'h00;

  logic       vma, e_lvl, cia_sel, cia_we, strobe, ack;
  logic [7:0] rdat, wait_cnt;
  logic       vma2, e_lvl2, cia_sel2, cia_we2, strobe2, ack2;
  logic [7:0] rdat2;
  logic [1:0] wait_cnt2;

  cia_eclk_bus_sync #(.WAIT_W(8)) dut (
    .clk_28(clk_28), .rst_n(rst_n), .clk7_en(clk7_en), .eclk(eclk),
    .req(req), .rnw(rnw), .cia_dout(cia_dout),
    .vma(vma), .e_lvl(e_lvl), .cia_sel(cia_sel), .cia_we(cia_we),
    .strobe(strobe), .ack(ack), .rdat(rdat), .wait_cnt(wait_cnt)
  );

  cia_eclk_bus_sync #(.WAIT_W(2)) dut2 (
    .clk_28(clk_28), .rst_n(rst_n), .clk7_en(clk7_en), .eclk(eclk),
    .req(req), .rnw(rnw), .cia_dout(cia_dout),
    .vma(vma2), .e_lvl(e_lvl2), .cia_sel(cia_sel2), .cia_we(cia_we2),
    .strobe(strobe2), .ack(ack2), .rdat(rdat2), .wait_cnt(wait_cnt2)
  );

  initial forever #5 clk_28 = ~clk_28;

  int passed = 0;
  int total = 0;
  int unsigned phase = 0;    // E phase presented at the next qualifying edge
  int unsigned sub = 0;
  int unsigned last_q = 0;   // E phase of the most recent qualifying edge
  bit kill = 1'b0;           // force eclk to all-zero
  int ack_cnt = 0;

  typedef struct {
    logic [7:0] rdat;
    logic [7:0] wcnt;
  } exp_t;
  exp_t sb[$];

  // One clk_28 cycle: advance the E/clk7 generator and score any ack.
  task automatic cyc();
    bit   was_q;
    exp_t e;
    @(posedge clk_28);
    #1;
    was_q = clk7_en;
    if (was_q) begin
      last_q = phase;
      phase = (phase == 9) ? 0 : phase + 1;
    end
    sub = (sub + 1) % 4;
    clk7_en = (sub == 0);
    eclk = kill ? 10'd0 : (10'b1 << phase);
    if (ack === 1'b1) begin
      ack_cnt++;
      total++;
      if (sb.size() == 0) begin
        $display("FAIL ack_unexpected: got ack=1 want no ack pending");
      end else begin
        e = sb.pop_front();
        if (rdat !== e.rdat || wait_cnt !== e.wcnt)
          $display("FAIL ack_data: got rdat=%h wait=%0d want rdat=%h wait=%0d",
                   rdat, wait_cnt, e.rdat, e.wcnt);
        else passed++;
      end
    end
  endtask

  // Consume exactly one qualifying edge.
  task automatic step7();
    bit w;
    w = 1'b0;
    for (int i = 0; i < 4 && !w; i++) begin
      w = clk7_en;
      cyc();
    end
  endtask

  // Step until the qualifying edge just consumed carried phase p.
  task automatic step_to(input int unsigned p);
    for (int i = 0; i < 12; i++) begin
      step7();
      if (last_q == p) return;
    end
    total++;
    $display("FAIL step_to_timeout: got no phase %0d edge want one within 12 periods", p);
  endtask

  // Position so that the next clk_28 edge is qualifying with phase p.
  task automatic wait_edge(input int unsigned p);
    for (int i = 0; i < 60; i++) begin
      if (clk7_en && phase == p) return;
      cyc();
    end
    total++;
    $display("FAIL wait_edge_timeout: got no phase %0d want one within 60 cycles", p);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    total++; if ({vma, e_lvl, cia_sel, cia_we, strobe, ack} !== 6'b0) $display("FAIL rst_outs: got %b want 000000", {vma, e_lvl, cia_sel, cia_we, strobe, ack}); else passed++;
    total++; if (rdat !== 8'h00 || wait_cnt !== 8'h00) $display("FAIL rst_regs: got rdat=%h wait=%0d want 00/0", rdat, wait_cnt); else passed++;
    rst_n = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic test_read_aligned();
    cia_dout = 8'hA5;
    wait_edge(0);
    req = 1'b1; rnw = 1'b1;
    sb.push_back('{8'hA5, 8'd1});
    cyc();
    total++; if (vma !== 1'b0 || wait_cnt !== 8'd0) $display("FAIL rd_sync: got vma=%b wait=%0d want 0/0", vma, wait_cnt); else passed++;
    step7();
    total++; if (wait_cnt !== 8'd1 || vma !== 1'b0) $display("FAIL rd_wait1: got wait=%0d vma=%b want 1/0", wait_cnt, vma); else passed++;
    step7();
    total++; if (vma !== 1'b1 || e_lvl !== 1'b0 || cia_sel !== 1'b0) $display("FAIL rd_vma: got vma=%b e=%b sel=%b want 1/0/0", vma, e_lvl, cia_sel); else passed++;
    step_to(5);
    total++; if (cia_sel !== 1'b1 || cia_we !== 1'b0) $display("FAIL rd_sel: got sel=%b we=%b want 1/0", cia_sel, cia_we); else passed++;
    step_to(6);
    total++; if (e_lvl !== 1'b1) $display("FAIL rd_elvl: got %b want 1", e_lvl); else passed++;
    step_to(8);
    total++; if (strobe !== 1'b0 || ack !== 1'b0 || cia_sel !== 1'b1) $display("FAIL rd_pre9: got stb=%b ack=%b sel=%b want 0/0/1", strobe, ack, cia_sel); else passed++;
    step_to(9);
    total++; if (strobe !== 1'b1 || ack !== 1'b1 || vma !== 1'b0 || cia_sel !== 1'b0) $display("FAIL rd_end: got stb=%b ack=%b vma=%b sel=%b want 1/1/0/0", strobe, ack, vma, cia_sel); else passed++;
    total++; if (rdat !== 8'hA5) $display("FAIL rd_rdat: got %h want a5", rdat); else passed++;
    cyc();
    total++; if (strobe !== 1'b0 || ack !== 1'b0 || e_lvl !== 1'b0) $display("FAIL rd_pulse: got stb=%b ack=%b e=%b want 0/0/0", strobe, ack, e_lvl); else passed++;
    req = 1'b0;
    step7();
  endtask

  task automatic test_write_worst();
    bit bad;
    cia_dout = 8'h3C;
    wait_edge(3);
    req = 1'b1; rnw = 1'b0;
    sb.push_back('{8'hA5, 8'd8});
    cyc();
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step7();
      if (vma !== 1'b0) bad = 1'b1;
    end
    total++; if (bad || wait_cnt !== 8'd8) $display("FAIL wr_wait: got wait=%0d early_vma=%b want 8/0", wait_cnt, bad); else passed++;
    step7();
    total++; if (vma !== 1'b1 || cia_we !== 1'b0 || cia_sel !== 1'b0) $display("FAIL wr_vma: got vma=%b we=%b sel=%b want 1/0/0", vma, cia_we, cia_sel); else passed++;
    step_to(5);
    total++; if (cia_sel !== 1'b1 || cia_we !== 1'b1) $display("FAIL wr_sel: got sel=%b we=%b want 1/1", cia_sel, cia_we); else passed++;
    step_to(9);
    total++; if (cia_sel !== 1'b0 || cia_we !== 1'b0 || strobe !== 1'b1 || rdat !== 8'hA5) $display("FAIL wr_end: got sel=%b we=%b stb=%b rdat=%h want 0/0/1/a5", cia_sel, cia_we, strobe, rdat); else passed++;
    cyc();
    req = 1'b0;
    step7();
  endtask

  task automatic test_withdraw();
    int a0;
    bit saw;
    a0 = ack_cnt;
    wait_edge(5);
    req = 1'b1; rnw = 1'b1;
    cyc();
    step7();
    req = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step7();
      if (vma !== 1'b0) saw = 1'b1;
    end
    total++; if (saw || ack_cnt != a0) $display("FAIL wd_sync: got vma_seen=%b acks=%0d want 0/%0d", saw, ack_cnt, a0); else passed++;

    cia_dout = 8'h5A;
    wait_edge(0);
    req = 1'b1; rnw = 1'b1;
    sb.push_back('{8'h5A, 8'd1});
    cyc();
    step_to(2);
    total++; if (vma !== 1'b1) $display("FAIL wd_vma: got %b want 1", vma); else passed++;
    req = 1'b0;
    step_to(9);
    total++; if (ack_cnt != a0 + 1 || rdat !== 8'h5A) $display("FAIL wd_late: got acks=%0d rdat=%h want %0d/5a", ack_cnt, rdat, a0 + 1); else passed++;
    for (int i = 0; i < 10; i++) step7();
    total++; if (ack_cnt != a0 + 1 || vma !== 1'b0) $display("FAIL wd_once: got acks=%0d vma=%b want %0d/0", ack_cnt, vma, a0 + 1); else passed++;
  endtask

  task automatic test_back_to_back();
    int a0;
    int unsigned p;
    int w;
    bit saw;
    a0 = ack_cnt;
    wait_edge(7);
    req = 1'b1; rnw = 1'b0;
    sb.push_back('{8'h5A, 8'd4});
    cyc();
    step_to(2);
    step_to(9);
    total++; if (ack_cnt != a0 + 1) $display("FAIL b2b_first: got acks=%0d want %0d", ack_cnt, a0 + 1); else passed++;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step7();
      if (vma !== 1'b0) saw = 1'b1;
    end
    total++; if (saw || ack_cnt != a0 + 1) $display("FAIL b2b_held: got vma_seen=%b acks=%0d want 0/%0d", saw, ack_cnt, a0 + 1); else passed++;
    req = 1'b0;
    step7();
    req = 1'b1; rnw = 1'b1; cia_dout = 8'hC3;
    w = 0;
    p = (phase + 1) % 10;
    while (p != 2) begin w++; p = (p + 1) % 10; end
    sb.push_back('{8'hC3, 8'(w)});
    step7();
    total++; if (wait_cnt !== 8'd0 || vma !== 1'b0) $display("FAIL b2b_restart: got wait=%0d vma=%b want 0/0", wait_cnt, vma); else passed++;
    step_to(2);
    step_to(9);
    total++; if (ack_cnt != a0 + 2 || rdat !== 8'hC3) $display("FAIL b2b_second: got acks=%0d rdat=%h want %0d/c3", ack_cnt, rdat, a0 + 2); else passed++;
    req = 1'b0;
    step7();
    total++; if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending want 0", sb.size()); else passed++;
  endtask

  task automatic test_saturation();
    wait_edge(3);
    req = 1'b1; rnw = 1'b1;
    cyc();
    kill = 1'b1;
    eclk = 10'd0;
    for (int i = 0; i < 3; i++) step7();
    total++; if (wait_cnt2 !== 2'd3 || wait_cnt !== 8'd3) $display("FAIL sat_3: got w2=%0d w8=%0d want 3/3", wait_cnt2, wait_cnt); else passed++;
    for (int i = 0; i < 3; i++) step7();
    total++; if (wait_cnt2 !== 2'd3 || wait_cnt !== 8'd6 || vma !== 1'b0) $display("FAIL sat_6: got w2=%0d w8=%0d vma=%b want 3/6/0", wait_cnt2, wait_cnt, vma); else passed++;
    req = 1'b0;
    step7();
    kill = 1'b0;
    eclk = 10'b1 << phase;
    for (int i = 0; i < 12; i++) step7();
    total++; if (vma !== 1'b0 || vma2 !== 1'b0) $display("FAIL sat_exit: got vma=%b vma2=%b want 0/0", vma, vma2); else passed++;
  endtask

  task automatic test_reset_midcycle();
    int a0;
    bit saw;
    cia_dout = 8'h77;
    wait_edge(0);
    req = 1'b1; rnw = 1'b1;
    sb.push_back('{8'h77, 8'd1});
    cyc();
    step_to(2);
    step_to(5);
    total++; if (cia_sel !== 1'b1) $display("FAIL rstm_pre: got sel=%b want 1", cia_sel); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({vma, e_lvl, cia_sel, cia_we, strobe, ack} !== 6'b0) $display("FAIL rstm_async: got %b want 000000", {vma, e_lvl, cia_sel, cia_we, strobe, ack}); else passed++;
    total++; if (rdat !== 8'h00 || wait_cnt !== 8'h00) $display("FAIL rstm_regs: got rdat=%h wait=%0d want 00/0", rdat, wait_cnt); else passed++;
    sb.delete();
    a0 = ack_cnt;
    req = 1'b0;
    repeat (4) cyc();
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step7();
      if (vma !== 1'b0) saw = 1'b1;
    end
    total++; if (saw || ack_cnt != a0) $display("FAIL rstm_after: got vma_seen=%b acks=%0d want 0/%0d", saw, ack_cnt, a0); else passed++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read_aligned();
    test_write_worst();
    test_withdraw();
    test_back_to_back();
    test_saturation();
    test_reset_midcycle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
